// File: rtl/alu_pkg.sv
// Shared opcodes, multiply-op bit positions and FSM encodings for alu_mul_unit and alu_dp.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  // mul_op = {long, signed, accumulate}
  localparam int MUL_ACC  = 0;
  localparam int MUL_SGN  = 1;
  localparam int MUL_LONG = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // TST/TEQ/CMP/CMN (8..B) only update flags.
  function automatic logic writes_rd(input logic [3:0] op);
    return op[3:2] != 2'b10;
  endfunction

endpackage

// File: rtl/alu_mul_unit_if.sv
// Execute-stage request/result bundle between the core (master) and alu_mul_unit (slave).
interface alu_mul_unit_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic         is_mul;
  logic [3:0]   opcode;
  logic [2:0]   mul_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] acc_lo;
  logic [W-1:0] acc_hi;
  logic         n, z, c, v;
  logic         shifter_carry_out;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_lo;
  logic [W-1:0] out_hi;
  logic         out_n, out_z, out_c, out_v;
  logic         wrd;
  logic         busy;

  modport master (
    output in_valid, is_mul, opcode, mul_op, a, b, acc_lo, acc_hi,
           n, z, c, v, shifter_carry_out, out_ready,
    input  in_ready, out_valid, out_lo, out_hi, out_n, out_z, out_c, out_v, wrd, busy
  );

  modport slave (
    input  in_valid, is_mul, opcode, mul_op, a, b, acc_lo, acc_hi,
           n, z, c, v, shifter_carry_out, out_ready,
    output in_ready, out_valid, out_lo, out_hi, out_n, out_z, out_c, out_v, wrd, busy
  );
endinterface

// File: rtl/alu_dp.sv
// Combinational W-bit ARM data-processing core with NZCV generation.
// Latency: 0 (pure combinational; the caller registers the result).
// Backpressure: none; evaluated every cycle.
module alu_dp
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   opcode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c,
  input  logic         v,
  input  logic         shifter_carry_out,
  output logic [W-1:0] res,
  output logic         res_n,
  output logic         res_z,
  output logic         res_c,
  output logic         res_v,
  output logic         wrd
);
  logic [W-1:0] x, y;
  logic [W:0]   sum;
  logic         cin;
  logic         arith;

  // Every subtract is x + ~y + cin, so carry out is NOT-borrow.
  always_comb begin
    x     = a;
    y     = b;
    cin   = 1'b0;
    arith = 1'b1;
    case (opcode)
      OP_SUB, OP_CMP: begin y = ~b; cin = 1'b1; end
      OP_RSB:         begin x = b;  y = ~a; cin = 1'b1; end
      OP_ADD, OP_CMN: ;
      OP_ADC:         cin = c;
      OP_SBC:         begin y = ~b; cin = c; end
      OP_RSC:         begin x = b;  y = ~a; cin = c; end
      default:        arith = 1'b0;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
  end

  always_comb begin
    case (opcode)
      OP_AND, OP_TST: res = a & b;
      OP_EOR, OP_TEQ: res = a ^ b;
      OP_ORR:         res = a | b;
      OP_MOV:         res = b;
      OP_BIC:         res = a & ~b;
      OP_MVN:         res = ~b;
      default:        res = sum[W-1:0];
    endcase
  end

  assign res_n = res[W-1];
  assign res_z = (res == '0);
  assign res_c = arith ? sum[W] : shifter_carry_out;
  assign res_v = arith ? ((x[W-1] == y[W-1]) && (sum[W-1] != x[W-1])) : v;
  assign wrd   = writes_rd(opcode);

endmodule

// File: rtl/alu_mul_unit.sv
// Execute-stage ALU with registered data-processing result and iterative BPC-bit/cycle multiplier.
// Latency: data-processing 1 cycle; multiply W/BPC+1 cycles (MUL_EARLY_TERM_EN: as low as 2).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE or while DONE drains.
module alu_mul_unit
  import alu_pkg::*;
#(
  parameter int W   = 32,
  parameter int BPC = 2
) (
  input logic           clk,
  input logic           rst,
  alu_mul_unit_if.slave bus
);
  localparam int STEPS = W / BPC;
  localparam int CW    = $clog2(STEPS + 1);

  state_t         state, state_nx;
  logic           accept, rdy, mul_last;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] prod, mcand, step_sum, mcand_nx, prod_fin;
  logic [W-1:0]   mplier, mplier_nx;
  logic           m_long, m_sgn, m_c, m_v;
  logic [W-1:0]   dp_res;
  logic           dp_n, dp_z, dp_c, dp_v, dp_wrd;
  logic [W-1:0]   r_lo, r_hi;
  logic           r_n, r_z, r_c, r_v, r_wrd;
  logic           unused_flags;

  // N and Z are always regenerated from the result.
  assign unused_flags = ^{bus.n, bus.z};

  alu_dp #(.W(W)) u_dp (
    .opcode            (bus.opcode),
    .a                 (bus.a),
    .b                 (bus.b),
    .c                 (bus.c),
    .v                 (bus.v),
    .shifter_carry_out (bus.shifter_carry_out),
    .res               (dp_res),
    .res_n             (dp_n),
    .res_z             (dp_z),
    .res_c             (dp_c),
    .res_v             (dp_v),
    .wrd               (dp_wrd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    rdy      = 1'b0;
    case (state)
      ST_IDLE: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          accept   = 1'b1;
          state_nx = bus.is_mul ? ST_MUL : ST_DONE;
        end
      end
      ST_MUL: if (mul_last) state_nx = ST_DONE;
      ST_DONE: begin
        if (bus.out_ready) begin
          rdy = 1'b1;
          if (bus.in_valid) begin
            accept   = 1'b1;
            state_nx = bus.is_mul ? ST_MUL : ST_DONE;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Multiplier chunks are summed unsigned; a negative remaining multiplier
  // (all sign bits, i.e. -1) is folded in by subtracting the shifted multiplicand.
  always_comb begin
    step_sum = prod;
    for (int j = 0; j < BPC; j++) begin
      if (mplier[j]) step_sum = step_sum + (mcand << j);
    end
    mcand_nx  = mcand << BPC;
    mplier_nx = m_sgn ? W'($signed(mplier) >>> BPC) : (mplier >> BPC);
    prod_fin  = (m_sgn && mplier_nx[W-1]) ? (step_sum - mcand_nx) : step_sum;
  end

`ifdef MUL_EARLY_TERM_EN
  assign mul_last = (cnt == CW'(1)) || (mplier_nx == '0) || (m_sgn && (&mplier_nx));
`else
  assign mul_last = (cnt == CW'(1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      m_long <= 1'b0;
      m_sgn  <= 1'b0;
      m_c    <= 1'b0;
      m_v    <= 1'b0;
      r_lo   <= '0;
      r_hi   <= '0;
      r_n    <= 1'b0;
      r_z    <= 1'b0;
      r_c    <= 1'b0;
      r_v    <= 1'b0;
      r_wrd  <= 1'b0;
    end else if (accept) begin
      if (bus.is_mul) begin
        cnt    <= CW'(STEPS);
        m_long <= bus.mul_op[MUL_LONG];
        m_sgn  <= bus.mul_op[MUL_SGN];
        m_c    <= bus.c;
        m_v    <= bus.v;
        mcand  <= bus.mul_op[MUL_SGN] ? {{W{bus.a[W-1]}}, bus.a} : {{W{1'b0}}, bus.a};
        mplier <= bus.b;
        prod   <= !bus.mul_op[MUL_ACC] ? '0 :
                  {(bus.mul_op[MUL_LONG] ? bus.acc_hi : {W{1'b0}}), bus.acc_lo};
      end else begin
        r_lo  <= dp_res;
        r_hi  <= '0;
        r_n   <= dp_n;
        r_z   <= dp_z;
        r_c   <= dp_c;
        r_v   <= dp_v;
        r_wrd <= dp_wrd;
      end
    end else if (state == ST_MUL) begin
      cnt    <= cnt - CW'(1);
      prod   <= step_sum;
      mcand  <= mcand_nx;
      mplier <= mplier_nx;
      if (mul_last) begin
        r_lo  <= prod_fin[W-1:0];
        r_hi  <= m_long ? prod_fin[2*W-1:W] : {W{1'b0}};
        r_n   <= m_long ? prod_fin[2*W-1] : prod_fin[W-1];
        r_z   <= m_long ? (prod_fin == '0) : (prod_fin[W-1:0] == '0);
        r_c   <= m_c;
        r_v   <= m_v;
        r_wrd <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state == ST_MUL);
  assign bus.out_lo    = r_lo;
  assign bus.out_hi    = r_hi;
  assign bus.out_n     = r_n;
  assign bus.out_z     = r_z;
  assign bus.out_c     = r_c;
  assign bus.out_v     = r_v;
  assign bus.wrd       = r_wrd;

endmodule

// File: tb/tb_alu_mul_unit.sv
// Bench for alu_mul_unit: data-processing vector table, multiply corner sequences, queue scoreboard.
`timescale 1ns/1ps
module tb_alu_mul_unit;
  import alu_pkg::*;

  localparam int W   = 32;
  localparam int BPC = 2;
  localparam int MUL_MAX = W / BPC + 1;
`ifdef MUL_EARLY_TERM_EN
  localparam int MUL_MIN = 2;
  localparam int B3_MAX  = 3;
`else
  localparam int MUL_MIN = MUL_MAX;
  localparam int B3_MAX  = MUL_MAX;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mul_unit_if #(.W(W)) bus ();
  alu_mul_unit #(.W(W), .BPC(BPC)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] lo, hi;
    logic [3:0]  nzcv;
    logic        wrd;
    int          acc_cyc, lat_min, lat_max;
    string       name;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        c, v, sco;
    logic [31:0] lo;
    logic [3:0]  nzcv;
    logic        wrd;
  } dp_vec_t;

  exp_t    sbq[$];
  dp_vec_t dv[17];
  int checks = 0, errors = 0, cyc = 0, vstart = -1, w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk_exp(input logic [31:0] lo, hi, input logic [3:0] nzcv,
                                  input logic wrd, input int lmin, lmax, input string nm);
    exp_t e;
    e.lo = lo; e.hi = hi; e.nzcv = nzcv; e.wrd = wrd;
    e.acc_cyc = 0; e.lat_min = lmin; e.lat_max = lmax; e.name = nm;
    return e;
  endfunction

  function automatic logic [63:0] mul_model(input logic [2:0] mop, input logic [31:0] a, b, al, ah);
    logic [63:0] ea, eb, p;
    ea = mop[MUL_SGN] ? {{32{a[31]}}, a} : {32'h0, a};
    eb = mop[MUL_SGN] ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    if (mop[MUL_ACC]) p = p + (mop[MUL_LONG] ? {ah, al} : {32'h0, al});
    if (!mop[MUL_LONG]) p = {32'h0, p[31:0]};
    return p;
  endfunction

  // Drives one op from the next falling edge and holds it until accepted.
  task automatic issue(input logic is_mul, input logic [3:0] op, input logic [2:0] mop,
                       input logic [31:0] a, b, al, ah, input logic c, v, sco,
                       input exp_t e, output int waits);
    int k;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.is_mul = is_mul; bus.opcode = op; bus.mul_op = mop;
    bus.a = a; bus.b = b; bus.acc_lo = al; bus.acc_hi = ah;
    bus.n = 1'b0; bus.z = 1'b0; bus.c = c; bus.v = v; bus.shifter_carry_out = sco;
    for (k = 0; k < 200; k++) begin
      #1;
      if (bus.in_ready === 1'b1) break;
      @(negedge clk);
    end
    waits = k;
    if (k == 200) begin
      checks++; errors++;
      $display("FAIL %s_accept actual=timeout required=in_ready", e.name);
    end else begin
      e.acc_cyc = cyc;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int k;
    for (k = 0; k < 100 && sbq.size() != 0; k++) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_drain actual=%0d pending required=0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  // Scoreboard: compares on every out_valid & out_ready handshake.
  initial begin : monitor
    exp_t e;
    int lat;
    forever begin
      @(negedge clk); #2;
      if (bus.out_valid === 1'b1) begin
        if (vstart < 0) vstart = cyc;
        if (bus.out_ready === 1'b1) begin
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result actual=%0h required=none", bus.out_lo);
          end else begin
            e = sbq.pop_front();
            check(e.name, {bus.out_lo, bus.out_hi, bus.out_n, bus.out_z, bus.out_c, bus.out_v, bus.wrd},
                  {e.lo, e.hi, e.nzcv, e.wrd});
            lat = vstart - e.acc_cyc;
            checks++;
            if (lat < e.lat_min || lat > e.lat_max) begin
              errors++;
              $display("FAIL %s_latency actual=%0d required=%0d..%0d", e.name, lat, e.lat_min, e.lat_max);
            end
          end
          vstart = -1;
        end
      end else begin
        vstart = -1;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] ra, rb, ral, rah;
    logic [2:0]  rm;
    logic        rc, rv;
    logic [63:0] p;
    int k;

    dv[0]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'b0110, 1'b1};
    dv[1]  = '{OP_CMP, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 4'b0011, 1'b0};
    dv[2]  = '{OP_SUB, 32'h00000005, 32'h00000007, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFE, 4'b1000, 1'b1};
    dv[3]  = '{OP_RSB, 32'h00000001, 32'h00000010, 1'b0, 1'b0, 1'b0, 32'h0000000F, 4'b0010, 1'b1};
    dv[4]  = '{OP_ADC, 32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h80000000, 4'b1001, 1'b1};
    dv[5]  = '{OP_SBC, 32'h00000010, 32'h00000003, 1'b0, 1'b0, 1'b0, 32'h0000000C, 4'b0010, 1'b1};
    dv[6]  = '{OP_RSC, 32'h00000003, 32'h00000003, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'b0110, 1'b1};
    dv[7]  = '{OP_TST, 32'h000000F0, 32'h0000000F, 1'b0, 1'b1, 1'b1, 32'h00000000, 4'b0111, 1'b0};
    dv[8]  = '{OP_TEQ, 32'hFFFF0000, 32'hFFFF0000, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'b0100, 1'b0};
    dv[9]  = '{OP_CMN, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h80000000, 4'b1001, 1'b0};
    dv[10] = '{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b1, 1'b0, 32'hF000F000, 4'b1001, 1'b1};
    dv[11] = '{OP_EOR, 32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 4'b1010, 1'b1};
    dv[12] = '{OP_ORR, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b0, 32'h00000003, 4'b0000, 1'b1};
    dv[13] = '{OP_MOV, 32'h12345678, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'h00000000, 4'b0110, 1'b1};
    dv[14] = '{OP_BIC, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 32'hFFFF0000, 4'b1000, 1'b1};
    dv[15] = '{OP_MVN, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 4'b1001, 1'b1};
    dv[16] = '{OP_ADD, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'b0111, 1'b1};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.is_mul = 1'b0; bus.opcode = 4'h0; bus.mul_op = 3'b000;
    bus.a = '0; bus.b = '0; bus.acc_lo = '0; bus.acc_hi = '0;
    bus.n = 1'b0; bus.z = 1'b0; bus.c = 1'b0; bus.v = 1'b0; bus.shifter_carry_out = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
    check("reset_data", {bus.out_lo, bus.out_hi, bus.out_n, bus.out_z, bus.out_c, bus.out_v, bus.wrd}, '0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++)
      issue(1'b0, dv[i].op, 3'b000, dv[i].a, dv[i].b, '0, '0, dv[i].c, dv[i].v, dv[i].sco,
            mk_exp(dv[i].lo, 32'h0, dv[i].nzcv, dv[i].wrd, 1, 1, $sformatf("dp%0d", i)), w);
    drain("dp_table");

    // SMULL -2 * 3, operands scrambled while iterating.
    issue(1'b1, 4'h0, 3'b110, 32'hFFFFFFFE, 32'h00000003, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0,
          mk_exp(32'hFFFFFFFA, 32'hFFFFFFFF, 4'b1010, 1'b1, MUL_MIN, B3_MAX, "smull"), w);
    check("smull_busy", {bus.busy, bus.in_ready, bus.out_valid}, 3'b100);
    bus.a = 32'h0; bus.b = 32'h5A5A5A5A; bus.c = 1'b0; bus.v = 1'b1;
    drain("smull");

    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom; ral = $urandom; rah = $urandom;
      rm = 3'($urandom_range(0, 7)); rc = 1'($urandom); rv = 1'($urandom);
      if (i == 0) rb = 32'h00000001;
      if (i == 1) begin rb = 32'hFFFFFFFF; rm = 3'b110; end
      p = mul_model(rm, ra, rb, ral, rah);
      issue(1'b1, 4'h0, rm, ra, rb, ral, rah, rc, rv, 1'b0,
            mk_exp(p[31:0], p[63:32], {(rm[MUL_LONG] ? p[63] : p[31]), (p == 64'h0), rc, rv},
                   1'b1, MUL_MIN, MUL_MAX, $sformatf("rmul%0d", i)), w);
    end
    drain("rmul");

    // UMLAL with consumer stalled, then back-to-back MOV on release.
    bus.out_ready = 1'b0;
    issue(1'b1, 4'h0, 3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h0, 1'b0, 1'b1, 1'b0,
          mk_exp(32'h00000002, 32'hFFFFFFFE, 4'b1001, 1'b1, MUL_MIN, MUL_MAX, "umlal"), w);
    for (k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (bus.out_valid === 1'b1) break;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check($sformatf("umlal_hold%0d", i), {bus.out_valid, bus.in_ready, bus.out_hi, bus.out_lo},
            {1'b1, 1'b0, 32'hFFFFFFFE, 32'h00000002});
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    issue(1'b0, OP_MOV, 3'b000, 32'h0, 32'h00001234, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
          mk_exp(32'h00001234, 32'h0, 4'b0000, 1'b1, 1, 1, "b2b_mov"), w);
    check("b2b_accept_waits", 32'(w), 32'd0);
    drain("umlal_b2b");

    // Reset in the middle of a full-length multiply aborts it.
    issue(1'b1, 4'h0, 3'b000, 32'h00000005, 32'h80000001, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
          mk_exp(32'h0, 32'h0, 4'b0000, 1'b1, MUL_MIN, MUL_MAX, "aborted"), w);
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    sbq.delete();
    #1;
    check("rst_mid_mul", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
    @(negedge clk);
    rst = 1'b0;
    issue(1'b1, 4'h0, 3'b000, 32'd7, 32'd6, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
          mk_exp(32'd42, 32'h0, 4'b0000, 1'b1, MUL_MIN, MUL_MAX, "mul_7x6"), w);
    drain("mul_7x6");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mul_unit.md
Name: alu_mul_unit

Overview:
- Parametrised successor to the single-cycle combinational ALU.
- Executes all 16 ARM data-processing opcodes with a registered result.
- Adds an iterative multiplier for MUL, MLA, UMULL, UMLAL, SMULL and SMLAL, with valid/ready handshakes on both sides.
- Sits in the execute stage; the core stalls on in_ready/out_valid instead of assuming single-cycle completion.

Parameters:
- W, 32: datapath width in bits; long-multiply results are 2*W.
- BPC, 2: multiplier bits retired per cycle; must divide W; legal values 1, 2, 4, 8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit accepts the operation this cycle.
- is_mul  in  1  1 = multiply op, 0 = data-processing op.
- opcode  in  4  ARM data-processing opcode (0000 AND … 1111 MVN).
- mul_op  in  3  {long, signed, accumulate}.
- a  in  W  Rn / multiplicand.
- b  in  W  shifter operand / multiplier.
- acc_lo  in  W  accumulate low word (Rn for MLA, RdLo for long).
- acc_hi  in  W  accumulate high word (RdHi, long only).
- n, z, c, v  in  1 each  current CPSR flags.
- shifter_carry_out  in  1  barrel-shifter carry.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- out_lo  out  W  result / low word.
- out_hi  out  W  high word; 0 for non-long ops.
- out_n, out_z, out_c, out_v  out  1 each  new flags.
- wrd  out  1  destination write enable; 0 for TST/TEQ/CMP/CMN.
- busy  out  1  multiply iteration in progress.

Behaviour:
- Reset: state = IDLE; out_valid=0, busy=0, in_ready=1; out_lo=0, out_hi=0, all out flags=0, wrd=0.
- Reset asserted mid-multiply aborts the operation; no result is produced.
- States:
  - IDLE: accept when in_valid & in_ready. Data-processing op goes to DONE. Multiply op goes to MUL, with the counter loaded to W/BPC and the product accumulator loaded with acc (0 if not accumulate; acc_hi included only when long).
  - MUL: each cycle adds BPC partial products and decrements the counter. At counter==1 the final step completes and the state goes to DONE.
  - DONE: out_valid=1, outputs stable. On out_ready, go to IDLE; if a new in_valid arrives in the same cycle, accept it directly (back-to-back).
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Latency:
  - Data-processing: result valid the cycle after acceptance.
  - Multiply: W/BPC + 1 cycles (32/2 gives 17).
- Data-processing arithmetic, W-bit:
  - Carry is bit W of the (W+1)-bit sum/difference.
  - Subtract carry is NOT-borrow; SBC/RSC subtract ~c.
  - V per ARM overflow rule on operand and result MSBs.
  - Logical ops: C = shifter_carry_out, V = v.
  - N = out_lo[W-1]; Z = (out_lo==0).
- Multiply:
  - Short: out_lo = low W bits of a*b (+acc_lo); out_hi = 0.
  - Long: {out_hi,out_lo} = full 2W product (+{acc_hi,acc_lo}); unsigned or two's-complement signed per mul_op.
  - N = MSB of result (bit W-1 short, 2W-1 long); Z over full result width; C = c; V = v.
  - wrd = 1.
- Operands are captured at acceptance; input changes during MUL are ignored.
- out_ready held low keeps DONE indefinitely; no result is dropped or overwritten.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined: MUL leaves early once the remaining unconsumed multiplier bits are all 0 (unsigned) or all sign bits (signed). Those cases are then handled by a single correction step, exactly as ARM7 early termination. Minimum multiply latency is 2 cycles; results are bit-identical to the full-iteration case.
- Undefined: multiply latency is always W/BPC + 1.

Decomposition:
- Shared package/header alu_pkg:
  - Opcode localparams (OP_AND … OP_MVN).
  - mul_op bit positions (MUL_ACC, MUL_SGN, MUL_LONG).
  - State encodings (ST_IDLE, ST_MUL, ST_DONE).
- Sub-module alu_dp: combinational W-bit data-processing core with flag logic, instantiated by alu_mul_unit. The iterative multiplier stays in the top module.

Test Plan:
- ADDS 0xFFFFFFFF + 0x00000001 → next cycle out_lo=0, Z=1, C=1, V=0, N=0, wrd=1.
- CMP 0x80000000 vs 0x00000001 → out_lo=0x7FFFFFFF, C=1, V=1, N=0, wrd=0.
- SMULL a=0xFFFFFFFE (-2), b=0x00000003 → out_valid exactly 17 cycles after acceptance (no EARLY_TERM); {hi,lo}=0xFFFFFFFF_FFFFFFFA, N=1, C/V unchanged.
- UMLAL a=0xFFFFFFFF, b=0xFFFFFFFF, acc={0,1} → {hi,lo}=0xFFFFFFFE_00000002; out_ready low 5 cycles → outputs held; then back-to-back MOV accepted in the same cycle as out_ready.
- rst pulsed mid-MUL at cycle 8 → out_valid=0, in_ready=1 immediately; next MUL 7*6 → out_lo=42.
- With MUL_EARLY_TERM_EN: MUL b=0x00000003 → valid within 2–3 cycles; result equals the full-iteration run; W=16 build passes the same cases.
